// File: rtl/cpu_common_pkg.sv
// Shared CPU datapath types: register address, machine word and the
// write-back request that carries one pending register-file write.
package cpu_common;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned NUM_REGS = 32;

  typedef logic [4:0]      regaddr_t;
  typedef logic [XLEN-1:0] word_t;

  typedef struct packed {
    regaddr_t addr;
    word_t    data;
  } wb_req_t;

endpackage

// File: rtl/regfile_writeback_wb_fifo.sv
// Synchronous FIFO of write-back requests. Pointers carry an extra wrap bit
// so that full and empty can be told apart when the index bits match.
module wb_fifo
  import cpu_common::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  logic    push_i,
  input  wb_req_t push_data_i,
  input  logic    pop_i,
  output wb_req_t head_o,
  output logic    full_o,
  output logic    empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0] wr_ptr_q;
  logic [AW:0] rd_ptr_q;
  wb_req_t     mem_q [DEPTH];

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  // Advance the pointers on accepted push/pop; reset drops all contents.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i && !full_o) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_i && !empty_o) rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // Storage needs no reset: slots are only read between push and pop.
  always_ff @(posedge clk_i) begin
    if (push_i && !full_o) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/regfile_writeback.sv
// Register-file writer: arbitrates ALU and queued load results onto the
// single write port, tracks pending destinations, and forwards the write
// being presented this cycle to both operand read ports.
module regfile_writeback
  import cpu_common::*;
#(
  parameter int unsigned LD_FIFO_DEPTH = 2,
  parameter int unsigned STARVE_LIMIT  = 3
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     reserve_i,
  input  regaddr_t reserve_addr_i,
  input  logic     alu_valid_i,
  output logic     alu_ready_o,
  input  regaddr_t alu_addr_i,
  input  word_t    alu_data_i,
  input  logic     ld_valid_i,
  output logic     ld_ready_o,
  input  regaddr_t ld_addr_i,
  input  word_t    ld_data_i,
  output logic     rf_write_enable_o,
  output regaddr_t rf_write_addr_o,
  output word_t    rf_write_data_o,
  output logic [NUM_REGS-1:0] busy_o,
  input  regaddr_t rs1_addr_i,
  output logic     rs1_fwd_valid_o,
  output word_t    rs1_fwd_data_o,
  input  regaddr_t rs2_addr_i,
  output logic     rs2_fwd_valid_o,
  output word_t    rs2_fwd_data_o
);

  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_LIMIT);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [NUM_REGS-1:0] X0_MASK = {{(NUM_REGS-1){1'b1}}, 1'b0};

  wb_req_t       ld_req;
  wb_req_t       fifo_head;
  logic          fifo_push;
  logic          fifo_full;
  logic          fifo_empty;
  logic          starve;
  logic          alu_win;
  logic          fifo_win;
  wb_req_t       win_req;
  logic          win_we;
  logic [CW-1:0] starve_cnt_q;
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_set;
  logic [NUM_REGS-1:0] busy_clr;

  // Loads to x0 are acknowledged but never enqueued.
  assign ld_req     = '{addr: ld_addr_i, data: ld_data_i};
  assign ld_ready_o = !fifo_full;
  assign fifo_push  = ld_valid_i && !fifo_full && (ld_addr_i != '0);

  wb_fifo #(
    .DEPTH (LD_FIFO_DEPTH)
  ) u_ld_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (fifo_push),
    .push_data_i (ld_req),
    .pop_i       (fifo_win),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // Pick this cycle's writer: ALU first unless a waiting load has starved.
  always_comb begin
    starve   = (starve_cnt_q == CNT_MAX) && !fifo_empty;
    alu_win  = alu_valid_i && !starve;
    fifo_win = !alu_win && !fifo_empty;
    win_req  = '0;
    if (alu_win) begin
      win_req = '{addr: alu_addr_i, data: alu_data_i};
    end else if (fifo_win) begin
      win_req = fifo_head;
    end
    win_we = (alu_win || fifo_win) && (win_req.addr != '0);
  end

  assign alu_ready_o = !starve;

  // Stage the winner onto the regfile write port.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rf_write_enable_o <= 1'b0;
      rf_write_addr_o   <= '0;
      rf_write_data_o   <= '0;
    end else begin
      rf_write_enable_o <= win_we;
      rf_write_addr_o   <= win_req.addr;
      rf_write_data_o   <= win_req.data;
    end
  end

  // Count consecutive ALU wins over a waiting load, saturating at the limit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_cnt_q <= '0;
    end else if (fifo_empty || fifo_win) begin
      starve_cnt_q <= '0;
    end else if (alu_win && (starve_cnt_q != CNT_MAX)) begin
      starve_cnt_q <= starve_cnt_q + CNT_ONE;
    end
  end

  // Decode reservation and commit into per-register set/clear masks.
  always_comb begin
    busy_set = '0;
    busy_clr = '0;
    if (reserve_i)         busy_set[reserve_addr_i]  = 1'b1;
    if (rf_write_enable_o) busy_clr[rf_write_addr_o] = 1'b1;
  end

  // Pending-write scoreboard; a same-cycle set overrides the clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
    end else begin
      busy_q <= ((busy_q & ~busy_clr) | busy_set) & X0_MASK;
    end
  end

  assign busy_o = busy_q;

  assign rs1_fwd_valid_o = rf_write_enable_o && (rf_write_addr_o == rs1_addr_i) && (rs1_addr_i != '0);
  assign rs1_fwd_data_o  = rf_write_data_o;
  assign rs2_fwd_valid_o = rf_write_enable_o && (rf_write_addr_o == rs2_addr_i) && (rs2_addr_i != '0);
  assign rs2_fwd_data_o  = rf_write_data_o;

endmodule

// File: tb/tb_regfile_writeback.sv
// Randomised scoreboard bench for regfile_writeback with a queue-based
// reference model of the load FIFO, arbitration, scoreboard and forwarding.
module tb_regfile_writeback;
  import cpu_common::*;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned LIMIT = 3;

  logic     clk_i = 1'b0;
  logic     rst_ni = 1'b0;
  logic     reserve_i = 1'b0;
  regaddr_t reserve_addr_i = '0;
  logic     alu_valid_i = 1'b0;
  logic     alu_ready_o;
  regaddr_t alu_addr_i = '0;
  word_t    alu_data_i = '0;
  logic     ld_valid_i = 1'b0;
  logic     ld_ready_o;
  regaddr_t ld_addr_i = '0;
  word_t    ld_data_i = '0;
  logic     rf_write_enable_o;
  regaddr_t rf_write_addr_o;
  word_t    rf_write_data_o;
  logic [31:0] busy_o;
  regaddr_t rs1_addr_i = '0;
  logic     rs1_fwd_valid_o;
  word_t    rs1_fwd_data_o;
  regaddr_t rs2_addr_i = '0;
  logic     rs2_fwd_valid_o;
  word_t    rs2_fwd_data_o;

  always #5 clk_i = ~clk_i;

  regfile_writeback #(
    .LD_FIFO_DEPTH (DEPTH),
    .STARVE_LIMIT  (LIMIT)
  ) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .reserve_i         (reserve_i),
    .reserve_addr_i    (reserve_addr_i),
    .alu_valid_i       (alu_valid_i),
    .alu_ready_o       (alu_ready_o),
    .alu_addr_i        (alu_addr_i),
    .alu_data_i        (alu_data_i),
    .ld_valid_i        (ld_valid_i),
    .ld_ready_o        (ld_ready_o),
    .ld_addr_i         (ld_addr_i),
    .ld_data_i         (ld_data_i),
    .rf_write_enable_o (rf_write_enable_o),
    .rf_write_addr_o   (rf_write_addr_o),
    .rf_write_data_o   (rf_write_data_o),
    .busy_o            (busy_o),
    .rs1_addr_i        (rs1_addr_i),
    .rs1_fwd_valid_o   (rs1_fwd_valid_o),
    .rs1_fwd_data_o    (rs1_fwd_data_o),
    .rs2_addr_i        (rs2_addr_i),
    .rs2_fwd_valid_o   (rs2_fwd_valid_o),
    .rs2_fwd_data_o    (rs2_fwd_data_o)
  );

  typedef struct {
    int       cyc;
    regaddr_t addr;
    word_t    data;
  } exp_t;

  // Reference model state
  exp_t        exp_q[$];
  wb_req_t     ldq_m[$];
  int          cnt_m;
  logic [31:0] busy_m;
  bit          cur_we_m;
  regaddr_t    cur_addr_m;
  word_t       cur_data_m;
  bit          alu_acc_m;
  bit          ld_acc_m;
  int          cyc;

  int n_checks = 0;
  int n_fail   = 0;
  bit done     = 0;

  // Staged stimulus, applied just after a falling edge
  bit       nx_res;   regaddr_t nx_res_addr;
  bit       nx_alu_v; regaddr_t nx_alu_addr; word_t nx_alu_data;
  bit       nx_ld_v;  regaddr_t nx_ld_addr;  word_t nx_ld_data;
  regaddr_t nx_rs1;   regaddr_t nx_rs2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    ldq_m.delete();
    cnt_m      = 0;
    busy_m     = '0;
    cur_we_m   = 0;
    cur_addr_m = '0;
    cur_data_m = '0;
    alu_acc_m  = 0;
    ld_acc_m   = 0;
  endtask

  // One clock edge of the specified behaviour, using pre-edge state and inputs.
  task automatic model_update();
    bit      nonempty;
    bit      starve;
    bit      pop;
    bit      wv;
    wb_req_t w;
    nonempty  = (ldq_m.size() != 0);
    starve    = (cnt_m == LIMIT) && nonempty;
    alu_acc_m = alu_valid_i && !starve;
    pop       = !alu_acc_m && nonempty;
    ld_acc_m  = ld_valid_i && (ldq_m.size() < DEPTH);
    wv = 0;
    w  = '0;
    if (alu_acc_m) begin
      w.addr = alu_addr_i; w.data = alu_data_i; wv = 1;
    end else if (pop) begin
      w = ldq_m.pop_front(); wv = 1;
    end
    if (cur_we_m) busy_m[cur_addr_m] = 1'b0;
    if (reserve_i) busy_m[reserve_addr_i] = 1'b1;
    busy_m[0] = 1'b0;
    if (!nonempty || pop) cnt_m = 0;
    else if (alu_acc_m && cnt_m < LIMIT) cnt_m++;
    if (ld_acc_m && ld_addr_i != 0) ldq_m.push_back('{addr: ld_addr_i, data: ld_data_i});
    cyc++;
    cur_we_m   = wv && (w.addr != 0);
    cur_addr_m = w.addr;
    cur_data_m = w.data;
    if (cur_we_m) exp_q.push_back('{cyc: cyc, addr: w.addr, data: w.data});
  endtask

  task automatic set_idle();
    nx_res = 0; nx_res_addr = '0;
    nx_alu_v = 0; nx_alu_addr = '0; nx_alu_data = '0;
    nx_ld_v = 0; nx_ld_addr = '0; nx_ld_data = '0;
    nx_rs1 = '0; nx_rs2 = '0;
  endtask

  task automatic step();
    @(negedge clk_i);
    #1;
    reserve_i = nx_res;   reserve_addr_i = nx_res_addr;
    alu_valid_i = nx_alu_v; alu_addr_i = nx_alu_addr; alu_data_i = nx_alu_data;
    ld_valid_i = nx_ld_v; ld_addr_i = nx_ld_addr; ld_data_i = nx_ld_data;
    rs1_addr_i = nx_rs1;  rs2_addr_i = nx_rs2;
    @(posedge clk_i);
    model_update();
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    #2;
    set_idle();
    reserve_i = 0; alu_valid_i = 0; ld_valid_i = 0;
    rst_ni = 1'b0;
    model_reset();
    repeat (2) @(negedge clk_i);
    #2;
    rst_ni = 1'b1;
  endtask

  // Monitor: compare every presented output against the model/scoreboard.
  initial begin
    exp_t e;
    bit   hit;
    bit   f1;
    bit   f2;
    forever begin
      @(negedge clk_i);
      if (done) break;
      if (!rst_ni) begin
        check("rst_we", rf_write_enable_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_ld_ready", ld_ready_o, 1);
        check("rst_alu_ready", alu_ready_o, 1);
        continue;
      end
      hit = (exp_q.size() != 0) && (exp_q[0].cyc == cyc);
      check("rf_we", rf_write_enable_o, hit);
      if (hit) begin
        e = exp_q.pop_front();
        if (rf_write_enable_o) begin
          check("rf_addr", rf_write_addr_o, e.addr);
          check("rf_data", rf_write_data_o, e.data);
        end
      end
      check("busy", busy_o, busy_m);
      check("ld_ready", ld_ready_o, ldq_m.size() < DEPTH);
      check("alu_ready", alu_ready_o, !((cnt_m == LIMIT) && (ldq_m.size() != 0)));
      f1 = cur_we_m && (cur_addr_m == rs1_addr_i) && (rs1_addr_i != 0);
      f2 = cur_we_m && (cur_addr_m == rs2_addr_i) && (rs2_addr_i != 0);
      check("rs1_fwd_valid", rs1_fwd_valid_o, f1);
      check("rs2_fwd_valid", rs2_fwd_valid_o, f2);
      if (f1) check("rs1_fwd_data", rs1_fwd_data_o, cur_data_m);
      if (f2) check("rs2_fwd_data", rs2_fwd_data_o, cur_data_m);
    end
  end

  // Stimulus
  initial begin
    int n_ld;
    cyc = 0;
    set_idle();
    model_reset();
    repeat (3) @(negedge clk_i);
    #2 rst_ni = 1'b1;

    // ALU x5 = 0x1234, forwarded on rs1
    nx_alu_v = 1; nx_alu_addr = 5; nx_alu_data = 32'h1234; nx_rs1 = 5;
    step();
    set_idle(); step();

    // Load and ALU both to x0, plus a reservation of x0
    nx_alu_v = 1; nx_alu_addr = 0; nx_alu_data = 32'hDEAD;
    nx_ld_v = 1; nx_ld_addr = 0; nx_ld_data = 32'hBEEF;
    nx_res = 1; nx_res_addr = 0;
    step();
    set_idle(); step(); step();

    // ALU every cycle while loads to x7 and x8 wait
    for (int i = 0; i < 12; i++) begin
      nx_alu_v = 1; nx_alu_addr = regaddr_t'(1 + (i % 4)); nx_alu_data = $urandom;
      nx_ld_v = (i < 2); nx_ld_addr = (i == 0) ? 5'd7 : 5'd8; nx_ld_data = $urandom;
      nx_rs1 = 7; nx_rs2 = 8;
      step();
    end
    set_idle(); repeat (3) step();

    // Fill FIFO, hold a third load until space frees
    n_ld = 0;
    nx_ld_v = 0;
    for (int i = 0; i < 20 && n_ld < 3; i++) begin
      nx_alu_v = 1; nx_alu_addr = 12; nx_alu_data = $urandom;
      if (!nx_ld_v) begin
        nx_ld_v = 1; nx_ld_addr = regaddr_t'(10 + n_ld); nx_ld_data = $urandom;
      end
      step();
      if (ld_acc_m) begin n_ld++; nx_ld_v = 0; end
    end
    check("third_load_accepted", n_ld, 3);
    set_idle(); repeat (4) step();

    // Scoreboard and forwarding on x9
    nx_res = 1; nx_res_addr = 9; step();
    set_idle(); nx_alu_v = 1; nx_alu_addr = 9; nx_alu_data = 32'hAA; nx_rs1 = 9; step();
    set_idle(); step();
    nx_res = 1; nx_res_addr = 9; step();
    set_idle(); nx_alu_v = 1; nx_alu_addr = 9; nx_alu_data = 32'h55; nx_rs2 = 9; step();
    set_idle(); nx_res = 1; nx_res_addr = 9; step();
    set_idle(); step(); step();

    // Reset with two loads queued
    nx_alu_v = 1; nx_alu_addr = 3; nx_alu_data = $urandom;
    nx_ld_v = 1; nx_ld_addr = 20; nx_ld_data = $urandom; nx_res = 1; nx_res_addr = 20; step();
    nx_ld_addr = 21; nx_ld_data = $urandom; nx_res_addr = 21; step();
    do_reset();
    set_idle(); repeat (4) step();

    // Randomised traffic with held handshakes and one mid-run reset
    set_idle();
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      if (!nx_alu_v || alu_acc_m) begin
        nx_alu_v = ($urandom_range(0, 3) != 0);
        nx_alu_addr = regaddr_t'($urandom_range(0, 31));
        nx_alu_data = $urandom;
      end
      if (!nx_ld_v || ld_acc_m) begin
        nx_ld_v = ($urandom_range(0, 2) == 0);
        nx_ld_addr = regaddr_t'($urandom_range(0, 31));
        nx_ld_data = $urandom;
      end
      nx_res = ($urandom_range(0, 3) == 0);
      nx_res_addr = regaddr_t'($urandom_range(0, 31));
      nx_rs1 = ($urandom_range(0, 1) == 0) ? nx_alu_addr : regaddr_t'($urandom_range(0, 31));
      nx_rs2 = ($urandom_range(0, 1) == 0) ? nx_ld_addr : regaddr_t'($urandom_range(0, 31));
      step();
    end

    // Drain outstanding loads, bounded
    set_idle();
    for (int i = 0; i < 20 && ldq_m.size() != 0; i++) step();
    step(); step();
    @(negedge clk_i);
    #1;
    check("drain_pending_writes", exp_q.size(), 0);
    check("drain_fifo_model", ldq_m.size(), 0);
    done = 1;
    @(negedge clk_i);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
